// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: decodes the command byte, then sequences
// burst writes into the register bank or burst reads into POCI.
module spi_reg_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 8
) (
   input  logic              sclk,
   input  logic              rstn,
   input  logic              byte_valid,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              frame_end,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic [6:0]        reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              poci_load,
   output logic [DATA_W-1:0] poci_data,
   output logic              busy,
   output logic              addr_err,
   output logic [7:0]        wr_count
);

   localparam logic [7:0] NR   = 8'(NUM_REGS);
   localparam logic [6:0] LAST = 7'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_LOAD = 2'd2,
      READ      = 2'd3
   } state_t;

   state_t            state_q;
   logic [6:0]        addr_q;
   logic [6:0]        reg_addr_q;
   logic [DATA_W-1:0] reg_wdata_q;
   logic              reg_we_q;
   logic              poci_load_q;
   logic [DATA_W-1:0] poci_data_q;
   logic              busy_q;
   logic              addr_err_q;
   logic [7:0]        wr_count_q;

   logic              in_rng_d;
   logic [6:0]        addr_inc_d;

   // In-range addresses wrap at the bank end; out-of-range ones run to 127 -> 0.
   assign in_rng_d   = ({1'b0, addr_q} < NR);
   assign addr_inc_d = (in_rng_d && addr_q == LAST) ? 7'd0 : addr_q + 7'd1;

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         poci_load_q <= 1'b0;
         poci_data_q <= '0;
         busy_q      <= 1'b0;
         addr_err_q  <= 1'b0;
         wr_count_q  <= '0;
      end else begin
         reg_we_q    <= 1'b0;
         poci_load_q <= 1'b0;
         if (frame_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (byte_valid) begin
                     addr_q     <= byte_in[6:0];
                     reg_addr_q <= byte_in[6:0];
                     busy_q     <= 1'b1;
                     state_q    <= byte_in[7] ? READ_LOAD : WRITE;
                  end
               end
               WRITE: begin
                  if (byte_valid) begin
                     if (in_rng_d) begin
                        reg_we_q    <= 1'b1;
                        reg_wdata_q <= byte_in;
                        reg_addr_q  <= addr_q;
                        if (wr_count_q != 8'hFF)
                           wr_count_q <= wr_count_q + 8'd1;
                     end else begin
                        addr_err_q <= 1'b1;
                     end
                     addr_q <= addr_inc_d;
                  end
               end
               READ_LOAD: begin
                  poci_load_q <= 1'b1;
                  if (in_rng_d) begin
                     poci_data_q <= reg_rdata;
                  end else begin
                     poci_data_q <= '0;
                     addr_err_q  <= 1'b1;
                  end
                  state_q <= READ;
               end
               READ: begin
                  if (byte_valid) begin
                     addr_q     <= addr_inc_d;
                     reg_addr_q <= addr_inc_d;
                     state_q    <= READ_LOAD;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign poci_load = poci_load_q;
   assign poci_data = poci_data_q;
   assign busy      = busy_q;
   assign addr_err  = addr_err_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: frame-level model checked every cycle, plus
// literal expectations on captured write/read streams.
module tb_spi_reg_ctrl;

   localparam int NR = 32;

   logic       sclk = 1'b0;
   logic       rstn = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_in = '0;
   logic       frame_end = 1'b0;
   logic [7:0] reg_rdata;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       poci_load;
   logic [7:0] poci_data;
   logic       busy;
   logic       addr_err;
   logic [7:0] wr_count;

   spi_reg_ctrl #(.NUM_REGS(NR), .DATA_W(8)) dut (
      .sclk       (sclk),
      .rstn       (rstn),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .frame_end  (frame_end),
      .reg_rdata  (reg_rdata),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .poci_load  (poci_load),
      .poci_data  (poci_data),
      .busy       (busy),
      .addr_err   (addr_err),
      .wr_count   (wr_count)
   );

   always #5 sclk = ~sclk;

   // Register bank; unimplemented addresses return a marker value.
   logic [7:0] bank [128];
   assign reg_rdata = (int'(reg_addr) < NR) ? bank[reg_addr] : 8'hEE;
   always @(posedge sclk) if (reg_we) bank[reg_addr] <= reg_wdata;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Address of the k-th access of a frame that started at s.
   function automatic logic [6:0] seq_addr(input logic [6:0] s, input int k);
      int t;
      t = int'(s) + k;
      if (int'(s) < NR) return 7'(t % NR);
      if (t < 128) return 7'(t);
      return 7'((t - 128) % NR);
   endfunction

   // Frame-level model state and expected outputs.
   logic       in_frame = 0, m_rd = 0, ld_pend = 0;
   logic [6:0] m_start = 0, ld_addr = 0, m_ra = 0;
   int         m_k = 0;
   logic       m_we = 0, m_ld = 0, m_err = 0;
   logic [7:0] m_wd = 0, m_pd = 0, m_cnt = 0;

   task automatic model_reset();
      in_frame = 0; m_rd = 0; ld_pend = 0; m_start = 0; ld_addr = 0;
      m_ra = 0; m_k = 0; m_we = 0; m_ld = 0; m_err = 0;
      m_wd = 0; m_pd = 0; m_cnt = 0;
   endtask

   always @(posedge sclk) begin : model
      logic [6:0] a;
      logic       fire;
      if (rstn) begin
         m_we = 0;
         m_ld = 0;
         fire = ld_pend;
         ld_pend = 0;
         if (frame_end) begin
            in_frame = 0;
         end else begin
            if (fire) begin
               m_ld = 1;
               if (int'(ld_addr) < NR) m_pd = bank[ld_addr];
               else begin m_pd = 8'h00; m_err = 1; end
            end
            if (byte_valid) begin
               if (!in_frame) begin
                  in_frame = 1;
                  m_rd = byte_in[7];
                  m_start = byte_in[6:0];
                  m_k = 0;
                  m_ra = m_start;
                  if (m_rd) begin ld_pend = 1; ld_addr = m_start; end
               end else if (!m_rd) begin
                  a = seq_addr(m_start, m_k);
                  m_k++;
                  if (int'(a) < NR) begin
                     m_we = 1; m_ra = a; m_wd = byte_in;
                     if (m_cnt != 8'hFF) m_cnt++;
                  end else m_err = 1;
               end else if (!fire) begin
                  m_k++;
                  a = seq_addr(m_start, m_k);
                  m_ra = a;
                  ld_pend = 1;
                  ld_addr = a;
               end
            end
         end
      end
   end

   logic [15:0] wr_q[$];
   logic [7:0]  rd_q[$];

   always @(negedge sclk) begin
      chk("reg_we", 16'(reg_we), 16'(m_we));
      chk("reg_addr", 16'(reg_addr), 16'(m_ra));
      chk("reg_wdata", 16'(reg_wdata), 16'(m_wd));
      chk("poci_load", 16'(poci_load), 16'(m_ld));
      chk("poci_data", 16'(poci_data), 16'(m_pd));
      chk("busy", 16'(busy), 16'(in_frame));
      chk("addr_err", 16'(addr_err), 16'(m_err));
      chk("wr_count", 16'(wr_count), 16'(m_cnt));
      if (reg_we) wr_q.push_back({1'b0, reg_addr, reg_wdata});
      if (poci_load) rd_q.push_back(poci_data);
   end

   task automatic drive(input logic v, input logic [7:0] b, input logic f);
      @(negedge sclk); #1;
      byte_valid = v; byte_in = b; frame_end = f;
      @(negedge sclk); #1;
      byte_valid = 0; frame_end = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sclk);
   endtask

   task automatic sb(input logic [7:0] b);
      drive(1'b1, b, 1'b0);
      idle(8);
   endtask

   task automatic fend();
      drive(1'b0, 8'h00, 1'b1);
      idle(2);
   endtask

   initial begin
      #3;
      chk("rst_we", 16'(reg_we), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_cnt", 16'(wr_count), 16'h0);
      chk("rst_addr", 16'(reg_addr), 16'h0);
      idle(2); #1;
      rstn = 1;

      // write burst at 5
      sb(8'h05); sb(8'hAA); sb(8'hBB); sb(8'hCC); fend();
      chk("burst_n", 16'(wr_q.size()), 16'd3);
      chk("burst_w0", wr_q[0], 16'h05AA);
      chk("burst_w1", wr_q[1], 16'h06BB);
      chk("burst_w2", wr_q[2], 16'h07CC);
      chk("burst_cnt", 16'(wr_count), 16'd3);
      chk("burst_err", 16'(addr_err), 16'd0);
      chk("burst_busy", 16'(busy), 16'd0);
      wr_q.delete();

      // wrap 31 -> 0
      sb(8'h1F); sb(8'h11); sb(8'h22); fend();
      chk("wrap_w0", wr_q[0], 16'h1F11);
      chk("wrap_w1", wr_q[1], 16'h0022);
      chk("wrap_err", 16'(addr_err), 16'd0);

      // preload 3..5 then read burst
      sb(8'h03); sb(8'h3C); sb(8'h4D); sb(8'h5E); fend();
      wr_q.delete();
      rd_q.delete();
      sb(8'h83); sb(8'h00); sb(8'h00); fend();
      chk("read_n", 16'(rd_q.size()), 16'd3);
      chk("read_0", 16'(rd_q[0]), 16'h3C);
      chk("read_1", 16'(rd_q[1]), 16'h4D);
      chk("read_2", 16'(rd_q[2]), 16'h5E);
      chk("read_nowe", 16'(wr_q.size()), 16'd0);

      // out of range
      sb(8'h40); sb(8'h99); fend();
      chk("oor_nowe", 16'(wr_q.size()), 16'd0);
      chk("oor_err", 16'(addr_err), 16'd1);
      rd_q.delete();
      sb(8'hC0); fend();
      chk("oor_rd", 16'(rd_q[0]), 16'h00);
      chk("oor_sticky", 16'(addr_err), 16'd1);

      // frame_end collides with second data byte
      sb(8'h08); sb(8'h12);
      drive(1'b1, 8'h34, 1'b1); idle(8);
      chk("col_busy", 16'(busy), 16'd0);
      sb(8'h0A); sb(8'h56); fend();
      chk("col_n", 16'(wr_q.size()), 16'd2);
      chk("col_w0", wr_q[0], 16'h0812);
      chk("col_w1", wr_q[1], 16'h0A56);
      wr_q.delete();

      // async reset while reg_we is high
      sb(8'h02);
      @(negedge sclk); #1;
      byte_valid = 1; byte_in = 8'h77;
      @(posedge sclk); #2;
      byte_valid = 0;
      chk("pre_rst_we", 16'(reg_we), 16'd1);
      rstn = 0;
      #1;
      model_reset();
      chk("arst_we", 16'(reg_we), 16'd0);
      chk("arst_cnt", 16'(wr_count), 16'd0);
      chk("arst_err", 16'(addr_err), 16'd0);
      chk("arst_busy", 16'(busy), 16'd0);
      @(negedge sclk); #1;
      rstn = 1;
      wr_q.delete();
      sb(8'h01); sb(8'h99); fend();
      chk("post_w", wr_q[0], 16'h0199);
      chk("post_cnt", 16'(wr_count), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
